// File: rtl/sw_pkg.sv
// Shared constants and types for the switch debouncer.
package sw_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CNT_W_DEF = 20;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/sw_debounce_ch.sv
// One debounce channel: synchroniser, stability counter,
// clean level and registered rise/fall pulses.
module sw_debounce_ch
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > CNT_MAX) begin : g_bad_cfg
    $error("sw_debounce_ch: DEBOUNCE_CYCLES out of range");
  end

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic db_q, db_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic sync;
  db_state_e state;

  assign sync = sync_q[SYNC_DEPTH-1];

  // Shift the raw pin through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], raw_i};
  end

  // A mismatch between synced input and level means a change is pending.
  always_comb begin
    state = (sync != db_q) ? COUNTING : STABLE;
  end

  // Count stable mismatch cycles; accept the new level on the last one.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    unique case (state)
      STABLE: begin
        cnt_d = '0;
      end
      COUNTING: begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          db_d   = sync;
          rise_d = sync;
          fall_d = ~sync;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// WIDTH independent switch debounce channels.
// Optional latching toggle output: SW_DEBOUNCE_TOGGLE_EN.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`ifdef SW_DEBOUNCE_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] sw_toggle
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .raw_i(sw_raw[i]),
      .db_o(sw_db[i]),
      .rise_o(sw_rise[i]),
      .fall_o(sw_fall[i])
    );
  end

`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [WIDTH-1:0] tog_q, tog_d;

  always_comb begin
    tog_d = tog_q ^ sw_rise;
  end

  // Flip each latch on the cycle after its rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign sw_toggle = tog_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (DEBOUNCE_CYCLES=4, WIDTH=2).
// Define SW_DEBOUNCE_TOGGLE_EN to also check sw_toggle.
module tb_sw_debounce;

  localparam int LAT = 6;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] db;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw_raw = 2'b00;
  logic [1:0] sw_db, sw_rise, sw_fall;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [1:0] sw_toggle;
  logic [1:0] tog_exp = 2'b00;
  logic       tog_chk = 1'b0;
`endif

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  ev_t  q[$];

  sw_debounce #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_raw(sw_raw),
    .sw_db(sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
`ifdef SW_DEBOUNCE_TOGGLE_EN
    ,
    .sw_toggle(sw_toggle)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int dly, input logic [1:0] r,
                           input logic [1:0] f, input logic [1:0] d);
    ev_t e;
    e.cyc = cyc + dly;
    e.rise = r;
    e.fall = f;
    e.db = d;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [1:0] act,
                     input logic [1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b want %b at cyc %0d", nm, act, req, cyc);
  endtask

  // Monitor: pop and compare on every pulse the DUT presents.
  always @(negedge clk) begin
`ifdef SW_DEBOUNCE_TOGGLE_EN
    if (!rst_n) tog_exp = 2'b00;
    if (tog_chk) begin
      chk("toggle_after", sw_toggle, tog_exp);
      tog_chk = 1'b0;
    end
`endif
    if (rst_n && ((sw_rise | sw_fall) != 2'b00)) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_pulse: rise %b fall %b db %b cyc %0d",
                 sw_rise, sw_fall, sw_db, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc == cyc && e.rise === sw_rise && e.fall === sw_fall &&
            e.db === sw_db) begin
          n_pass++;
        end else begin
          $display("FAIL pulse_event: got cyc %0d r %b f %b db %b want cyc %0d r %b f %b db %b",
                   cyc, sw_rise, sw_fall, sw_db, e.cyc, e.rise, e.fall, e.db);
        end
      end
`ifdef SW_DEBOUNCE_TOGGLE_EN
      chk("toggle_hold", sw_toggle, tog_exp);
      tog_exp = tog_exp ^ sw_rise;
      tog_chk = (sw_rise != 2'b00);
`endif
    end
  end

  initial begin
    // Reset with pins high.
    rst_n = 1'b0;
    sw_raw = 2'b11;
    step(3);
    @(negedge clk);
    chk("rst_db", sw_db, 2'b00);
    chk("rst_rise", sw_rise, 2'b00);
    chk("rst_fall", sw_fall, 2'b00);
    step(1);
    rst_n = 1'b1;
    expect_ev(LAT, 2'b11, 2'b00, 2'b11);
    step(10);
    sw_raw = 2'b00;
    expect_ev(LAT, 2'b00, 2'b11, 2'b00);
    step(10);

    // Clean step on bit 0.
    sw_raw = 2'b01;
    expect_ev(LAT, 2'b01, 2'b00, 2'b01);
    step(10);
    sw_raw = 2'b00;
    expect_ev(LAT, 2'b00, 2'b01, 2'b00);
    step(10);

    // Three-cycle glitch on bit 1 is rejected.
    sw_raw = 2'b10;
    step(3);
    sw_raw = 2'b00;
    step(10);
    @(negedge clk);
    chk("glitch_db", sw_db, 2'b00);
    step(1);

    // Bounce 1,0,1,1,1,1 on bit 1.
    sw_raw = 2'b10;
    step(1);
    sw_raw = 2'b00;
    step(1);
    sw_raw = 2'b10;
    expect_ev(LAT, 2'b10, 2'b00, 2'b10);
    step(10);
    sw_raw = 2'b00;
    expect_ev(LAT, 2'b00, 2'b10, 2'b00);
    step(10);

    // Reset mid-count restarts the full latency.
    sw_raw = 2'b01;
    step(4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_db", sw_db, 2'b00);
    step(2);
    rst_n = 1'b1;
    expect_ev(LAT, 2'b01, 2'b00, 2'b01);
    step(10);
    sw_raw = 2'b00;
    expect_ev(LAT, 2'b00, 2'b01, 2'b00);
    step(10);

    // Simultaneous edges on both bits.
    sw_raw = 2'b11;
    expect_ev(LAT, 2'b11, 2'b00, 2'b11);
    step(10);
    sw_raw = 2'b00;
    expect_ev(LAT, 2'b00, 2'b11, 2'b00);
    step(10);

    // Staggered by one cycle.
    sw_raw = 2'b01;
    expect_ev(LAT, 2'b01, 2'b00, 2'b01);
    step(1);
    sw_raw = 2'b11;
    expect_ev(LAT, 2'b10, 2'b00, 2'b11);
    step(10);
    sw_raw = 2'b00;
    expect_ev(LAT, 2'b00, 2'b11, 2'b00);
    step(10);

    // Three presses on bit 0.
    for (int i = 0; i < 3; i++) begin
      sw_raw = 2'b01;
      expect_ev(LAT, 2'b01, 2'b00, 2'b01);
      step(10);
      sw_raw = 2'b00;
      expect_ev(LAT, 2'b00, 2'b01, 2'b00);
      step(10);
    end

    // Held pins: nothing more may arrive.
    step(20);
    @(negedge clk);
    chk("final_db", sw_db, 2'b00);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL missing_events: %0d pending, first due cyc %0d",
                  q.size(), q[0].cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side conditioner for the board slide switches and buttons.
- Sits between the raw switch pins and any logic that consumes switch state, such as the LED mapping logic.
- Per bit: synchronises the raw level, filters bounce with a stability counter, and outputs a clean level plus one-cycle rise/fall pulses.
- WIDTH independent channels share one clock and reset.

Parameters:
- WIDTH, 2, number of switch channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range 2..2**CNT_W-1.
- CNT_W, 20, stability counter width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw asynchronous switch pins.
- sw_db  output  WIDTH  debounced level.
- sw_rise  output  WIDTH  one-cycle pulse on accepted 0->1.
- sw_fall  output  WIDTH  one-cycle pulse on accepted 1->0.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: sync flops, counters, sw_db, sw_rise and sw_fall are all 0.
- Synchroniser: two-flop synchroniser per bit; only the second stage (sync) is used downstream.
- States: per channel, STABLE (sync == sw_db) or COUNTING (sync != sw_db).
- STABLE: counter held at 0.
- STABLE -> COUNTING: when sync != sw_db; the counter increments every cycle the mismatch persists.
- COUNTING -> STABLE, accept:
  - Condition: count == DEBOUNCE_CYCLES-1 and mismatch still present.
  - On that edge, sw_db takes the sync value and the counter clears.
  - sw_rise (or sw_fall) is 1 for exactly that one cycle, aligned with the sw_db change.
- COUNTING -> STABLE, glitch: sync returns to sw_db before acceptance; the counter clears, no output change, no pulse.
- Latency: a clean step on sw_raw appears on sw_db 2 + DEBOUNCE_CYCLES clock edges after the first edge that samples it.
- Pulses:
  - Registered; never both high on one channel in the same cycle.
  - Never back-to-back on one channel, since the minimum spacing between accepts is DEBOUNCE_CYCLES cycles.
- Counter: never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
- Elaboration check: fail if DEBOUNCE_CYCLES < 2 or DEBOUNCE_CYCLES > 2**CNT_W-1.
- Channel independence: channels never interact; simultaneous changes on several bits are accepted independently and may pulse in the same cycle.
- Reset mid-count:
  - The count is discarded and sw_db returns to 0 regardless of pin level.
  - If the pin is held high, sw_db re-rises 2 + DEBOUNCE_CYCLES cycles after rst_n deasserts, with a sw_rise pulse.
- Pin held constant: no pulses ever.

Optional Feature:
- Macro: SW_DEBOUNCE_TOGGLE_EN.
- Defined:
  - Adds output sw_toggle [WIDTH], reset 0.
  - Each bit inverts on the cycle after its sw_rise pulse.
  - Turns push-buttons into latching controls.
- Undefined: no sw_toggle port, no toggle flops; all other behaviour is identical.

Decomposition:
- Package sw_pkg:
  - Constants: default DEBOUNCE_CYCLES, CNT_W, sync depth (2).
  - Enum typedef db_state_e {STABLE, COUNTING}.
- Sub-module sw_debounce_ch: one channel containing the synchroniser, counter, state, level and pulses.
- sw_debounce instantiates WIDTH copies of sw_debounce_ch in a generate loop and adds the optional toggle logic.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, WIDTH=2):
- Reset: rst_n=0 with sw_raw=2'b11 -> sw_db=0, sw_rise=0, sw_fall=0. Release rst_n -> sw_db=2'b11 after 6 cycles, with a one-cycle sw_rise=2'b11.
- Clean step: sw_raw[0] 0->1 and held -> sw_db[0]=1 exactly 6 edges later, with sw_rise[0]=1 for one cycle. Then 1->0 -> sw_fall[0] pulse after 6 edges; sw_db[1] stays 0 throughout.
- Glitch reject: sw_raw[1] high for 3 cycles, then low -> sw_db[1] never changes and no pulses occur. Bounce pattern 1,0,1,1,1,1 -> accepted 6 edges after the final 0->1.
- Reset mid-count: sw_raw[0]=1 for 3 synced cycles, then rst_n pulsed low -> counter cleared, sw_db[0]=0, full 6-cycle latency restarts after release.
- Simultaneous: both bits rise on the same edge -> sw_rise=2'b11 in one cycle. Staggering the bits by 1 cycle -> separate single pulses 1 cycle apart.
- Toggle (SW_DEBOUNCE_TOGGLE_EN defined): three accepted presses on bit 0 -> sw_toggle[0] goes 1,0,1, each change one cycle after its sw_rise. With the macro undefined, the port is absent and the bench compiles without it.
